bcd_multi_counter: RTL and testbench

BCD_MULTI_COUNTER -- requirements
Module: bcd_multi_counter

---
 rtl/bcd_cnt_pkg.sv | 23 ++
 rtl/bcd_digit_cell.sv | 43 ++++
 rtl/bcd_multi_counter.sv | 141 ++++++++++++++
 tb/tb_bcd_multi_counter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared constants and types for the BCD multi-digit counter.
// int_to_bcd turns an integer reset value into packed BCD at elaboration time.
package bcd_cnt_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_e;
   typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_e;

   function automatic logic [31:0] int_to_bcd(input int unsigned v);
      int unsigned r;
      logic [31:0] b;
      r = v;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: registered value with inc/dec enables, carry/borrow out and a
// load that clamps non-decimal nibbles to 9.
module bcd_digit_cell
   import bcd_cnt_pkg::*;
#(
   parameter logic [3:0] RST_DIGIT = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc_en,
   input  logic       dec_en,
   input  logic       load,
   input  logic [3:0] load_digit,
   output logic [3:0] digit,
   output logic [3:0] digit_next,
   output logic       carry_out,
   output logic       borrow_out,
   output logic       is_max,
   output logic       is_min
);

   logic [3:0] digit_q, digit_d;

   always_comb begin
      is_max     = (digit_q == BCD_MAX);
      is_min     = (digit_q == BCD_MIN);
      carry_out  = inc_en & is_max;
      borrow_out = dec_en & is_min;
      digit_d    = digit_q;
      if (load)        digit_d = (load_digit > BCD_MAX) ? BCD_MAX : load_digit;
      else if (inc_en) digit_d = is_max ? BCD_MIN : digit_q + 4'd1;
      else if (dec_en) digit_d = is_min ? BCD_MAX : digit_q - 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) digit_q <= RST_DIGIT;
      else        digit_q <= digit_d;
   end

   assign digit      = digit_q;
   assign digit_next = digit_d;

endmodule

// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter with two prescaled speeds, wrap/saturate
// bounds, clamped parallel load and a 2-flop synchronised reset release.
module bcd_multi_counter
   import bcd_cnt_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SLOW_DIV   = 100,
   parameter int FAST_DIV   = 10,
   parameter int RST_VALUE  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inc_req,
   input  logic                    dec_req,
   input  logic                    fast_req,
   input  logic                    slow_req,
   input  logic                    run,
   input  logic                    wrap_mode,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    dir_up,
   output logic                    fast,
   output logic                    step,
   output logic                    wrapped,
   output logic                    at_bound
);

   localparam int              W            = 4 * NUM_DIGITS;
   localparam int              PW           = $clog2(SLOW_DIV);
   localparam logic [31:0]     RST_BCD_FULL = int_to_bcd(RST_VALUE);
   localparam logic [W-1:0]    RST_BCD      = RST_BCD_FULL[W-1:0];
   localparam logic            RST_AT_BOUND = (RST_VALUE == 10**NUM_DIGITS - 1);
   localparam logic [PW-1:0]   SLOW_LAST    = PW'(SLOW_DIV - 1);
   localparam logic [PW-1:0]   FAST_LAST    = PW'(FAST_DIV - 1);

   // Assertion is immediate; release reaches the state flops two edges later.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n_int;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync_q <= '0;
      else      rst_sync_q <= rst_sync_d;
   end

   assign rst_n_int = rst_sync_q[1];

   dir_e          dir_q, dir_d;
   speed_e        speed_q, speed_d;
   logic [PW-1:0] presc_q, presc_d, presc_last;
   logic          step_q, step_d, wrapped_q, wrapped_d, at_bound_q, at_bound_d;
   logic          tick, all_max, all_min, do_inc, do_dec;

   logic [NUM_DIGITS-1:0]      inc_en, dec_en, carry, borrow, is_max, is_min;
   logic [NUM_DIGITS-1:0][3:0] digit, digit_next;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
         assign inc_en[i] = do_inc;
         assign dec_en[i] = do_dec;
      end else begin : g_upper
         assign inc_en[i] = carry[i-1];
         assign dec_en[i] = borrow[i-1];
      end

      bcd_digit_cell #(.RST_DIGIT(RST_BCD[4*i +: 4])) u_digit (
         .clk        (clk),
         .rst_n      (rst_n_int),
         .inc_en     (inc_en[i]),
         .dec_en     (dec_en[i]),
         .load       (load),
         .load_digit (load_value[4*i +: 4]),
         .digit      (digit[i]),
         .digit_next (digit_next[i]),
         .carry_out  (carry[i]),
         .borrow_out (borrow[i]),
         .is_max     (is_max[i]),
         .is_min     (is_min[i])
      );
   end

   // Tick uses the speed and direction already in effect; new requests apply from the next period.
   assign presc_last = (speed_q == FAST) ? FAST_LAST : SLOW_LAST;
   assign tick       = run & (presc_q == presc_last);
   assign all_max    = &is_max;
   assign all_min    = &is_min;
   assign do_inc     = tick & ~load & (dir_q == UP)   & (~all_max | wrap_mode);
   assign do_dec     = tick & ~load & (dir_q == DOWN) & (~all_min | wrap_mode);
   assign step_d     = do_inc | do_dec;
   assign wrapped_d  = carry[NUM_DIGITS-1] | borrow[NUM_DIGITS-1];

   always_comb begin
      dir_d = dir_q;
      if (inc_req & ~dec_req)      dir_d = UP;
      else if (dec_req & ~inc_req) dir_d = DOWN;

      speed_d = speed_q;
      if (fast_req & ~slow_req)      speed_d = FAST;
      else if (slow_req & ~fast_req) speed_d = SLOW;

      presc_d = presc_q;
      if (load | (speed_d != speed_q)) presc_d = '0;
      else if (run)                    presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      at_bound_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (dir_d == UP) at_bound_d = at_bound_d & (digit_next[i] == BCD_MAX);
         else             at_bound_d = at_bound_d & (digit_next[i] == BCD_MIN);
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         dir_q      <= UP;
         speed_q    <= SLOW;
         presc_q    <= '0;
         step_q     <= 1'b0;
         wrapped_q  <= 1'b0;
         at_bound_q <= RST_AT_BOUND;
      end else begin
         dir_q      <= dir_d;
         speed_q    <= speed_d;
         presc_q    <= presc_d;
         step_q     <= step_d;
         wrapped_q  <= wrapped_d;
         at_bound_q <= at_bound_d;
      end
   end

   assign value    = digit;
   assign dir_up   = (dir_q == UP);
   assign fast     = (speed_q == FAST);
   assign step     = step_q;
   assign wrapped  = wrapped_q;
   assign at_bound = at_bound_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Bench for bcd_multi_counter: integer reference model feeds a scoreboard queue
// checked every falling edge, plus directed scenario checks and random traffic.
module tb_bcd_multi_counter;

   localparam int MAXV = 9999;
   localparam int SDIV = 10;
   localparam int FDIV = 2;
   localparam int RSTV = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inc_req = 1'b0, dec_req = 1'b0, fast_req = 1'b0, slow_req = 1'b0;
   logic        run = 1'b0, wrap_mode = 1'b0, load = 1'b0;
   logic [15:0] load_value = '0;
   logic [15:0] value;
   logic        dir_up, fast, step, wrapped, at_bound;

   bcd_multi_counter #(
      .NUM_DIGITS(4), .SLOW_DIV(SDIV), .FAST_DIV(FDIV), .RST_VALUE(RSTV)
   ) dut (
      .clk(clk), .rst(rst), .inc_req(inc_req), .dec_req(dec_req),
      .fast_req(fast_req), .slow_req(slow_req), .run(run), .wrap_mode(wrap_mode),
      .load(load), .load_value(load_value), .value(value), .dir_up(dir_up),
      .fast(fast), .step(step), .wrapped(wrapped), .at_bound(at_bound)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] b;
      int r;
      r = v;
      b = '0;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic int from_bcd_clamp(input logic [15:0] b);
      int v, m, d;
      v = 0;
      m = 1;
      for (int i = 0; i < 4; i++) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) d = 9;
         v = v + d * m;
         m = m * 10;
      end
      return v;
   endfunction

   // Reference model: integer count, integer prescaler, reset release counter
   int m_val = RSTV, m_presc = 0, m_sync = 0;
   bit m_dir = 1'b1, m_fast = 1'b0, m_step = 1'b0, m_wrap = 1'b0, m_at = 1'b0;
   logic [20:0] exp_q[$];
   bit mon_en = 1'b1;

   task automatic model_reset();
      m_val = RSTV; m_presc = 0; m_dir = 1'b1; m_fast = 1'b0;
      m_step = 1'b0; m_wrap = 1'b0;
   endtask

   always @(posedge clk) begin
      if (mon_en) begin
         if (!rst) begin
            m_sync = 0;
            model_reset();
         end else if (m_sync < 2) begin
            m_sync++;
            model_reset();
         end else begin
            bit nd, nf, tk;
            nd = m_dir;
            if (inc_req && !dec_req) nd = 1'b1;
            else if (dec_req && !inc_req) nd = 1'b0;
            nf = m_fast;
            if (fast_req && !slow_req) nf = 1'b1;
            else if (slow_req && !fast_req) nf = 1'b0;
            tk = run && (m_presc == (m_fast ? FDIV : SDIV) - 1);
            m_step = 1'b0;
            m_wrap = 1'b0;
            if (load) m_val = from_bcd_clamp(load_value);
            else if (tk) begin
               if (m_dir) begin
                  if (m_val < MAXV) begin m_val++; m_step = 1'b1; end
                  else if (wrap_mode) begin m_val = 0; m_step = 1'b1; m_wrap = 1'b1; end
               end else begin
                  if (m_val > 0) begin m_val--; m_step = 1'b1; end
                  else if (wrap_mode) begin m_val = MAXV; m_step = 1'b1; m_wrap = 1'b1; end
               end
            end
            if (load || (nf != m_fast)) m_presc = 0;
            else if (run) m_presc = tk ? 0 : m_presc + 1;
            m_dir = nd;
            m_fast = nf;
         end
         m_at = m_dir ? (m_val == MAXV) : (m_val == 0);
         exp_q.push_back({to_bcd(m_val), m_dir, m_fast, m_step, m_wrap, m_at});
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            logic [20:0] e;
            e = exp_q.pop_front();
            chk("scoreboard", 32'({value, dir_up, fast, step, wrapped, at_bound}), 32'(e));
         end else begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      inc_req = 1'b0; dec_req = 1'b0; fast_req = 1'b0; slow_req = 1'b0; load = 1'b0;
   endtask

   // Returns at posedge+1 after both synchroniser edges; the next edge is the first live one.
   task automatic do_reset(input int n);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (n) @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nsteps, first, bad;
      logic [15:0] v0;

      #2 rst = 1'b0;
      do_reset(3);
      chk("rst_value", 32'(value), 32'h0001);
      chk("rst_dir_up", 32'(dir_up), 32'd1);
      chk("rst_fast", 32'(fast), 32'd0);
      chk("rst_at_bound", 32'(at_bound), 32'd0);

      // Slow counting from reset
      run = 1'b1; wrap_mode = 1'b0;
      nsteps = 0; first = 0; bad = 0;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         if (step) begin
            nsteps++;
            if (first == 0) first = i;
            if (i % 10 != 0) bad++;
         end
      end
      chk("slow_steps", 32'(nsteps), 32'd3);
      chk("slow_first_step", 32'(first), 32'd10);
      chk("slow_step_spacing", 32'(bad), 32'd0);
      chk("slow_value", 32'(value), 32'h0004);

      // Carry across digits, then saturate at the top
      load_value = 16'h0999; load = 1'b1; inc_req = 1'b1; fast_req = 1'b1;
      cyc();
      chk("load_0999", 32'(value), 32'h0999);
      chk("fast_set", 32'(fast), 32'd1);
      cyc();
      chk("carry_wait", 32'(value), 32'h0999);
      cyc();
      chk("carry_1000", 32'(value), 32'h1000);
      chk("carry_step", 32'(step), 32'd1);
      load_value = 16'h9999; load = 1'b1;
      cyc();
      nsteps = 0;
      repeat (6) begin cyc(); nsteps += int'(step); end
      chk("sat_value", 32'(value), 32'h9999);
      chk("sat_at_bound", 32'(at_bound), 32'd1);
      chk("sat_no_step", 32'(nsteps), 32'd0);

      // Wrap below zero
      wrap_mode = 1'b1; load_value = 16'h0000; load = 1'b1; dec_req = 1'b1;
      cyc();
      chk("down_dir", 32'(dir_up), 32'd0);
      chk("zero_at_bound", 32'(at_bound), 32'd1);
      cyc();
      cyc();
      chk("wrap_value", 32'(value), 32'h9999);
      chk("wrap_pulse", 32'(wrapped), 32'd1);
      nsteps = 0;
      repeat (2) begin cyc(); nsteps += int'(wrapped); end
      chk("wrap_once", 32'(nsteps), 32'd0);
      chk("after_wrap", 32'(value), 32'h9998);

      // Conflicting direction requests, then speed change mid-period
      inc_req = 1'b1; dec_req = 1'b1;
      cyc();
      chk("dir_conflict", 32'(dir_up), 32'd0);
      slow_req = 1'b1;
      cyc();
      chk("slow_set", 32'(fast), 32'd0);
      repeat (3) cyc();
      v0 = value;
      fast_req = 1'b1;
      cyc();
      chk("fast_edge_no_step", 32'(step), 32'd0);
      cyc();
      chk("fast_plus1_no_step", 32'(step), 32'd0);
      cyc();
      chk("fast_plus2_step", 32'(step), 32'd1);
      chk("fast_value", 32'(value), 32'(to_bcd(from_bcd_clamp(v0) - 1)));

      // Load coincident with a tick, with a clamped nibble
      cyc();
      load_value = 16'h12F4; load = 1'b1;
      cyc();
      chk("load_tick_value", 32'(value), 32'h1294);
      chk("load_tick_no_step", 32'(step), 32'd0);

      // run=0 holds the count but still honours requests
      run = 1'b0; v0 = value; inc_req = 1'b1;
      cyc();
      chk("hold_dir", 32'(dir_up), 32'd1);
      nsteps = 0;
      repeat (20) begin cyc(); nsteps += int'(step); end
      chk("hold_value", 32'(value), 32'(v0));
      chk("hold_no_step", 32'(nsteps), 32'd0);
      run = 1'b1;

      // Reset mid-count
      load_value = 16'h0057; load = 1'b1; slow_req = 1'b1; inc_req = 1'b1;
      cyc();
      repeat (4) cyc();
      chk("pre_rst_value", 32'(value), 32'h0057);
      do_reset(1);
      chk("mid_rst_value", 32'(value), 32'h0001);
      chk("mid_rst_dir", 32'(dir_up), 32'd1);
      chk("mid_rst_fast", 32'(fast), 32'd0);
      first = 0;
      for (int i = 1; i <= 15; i++) begin
         cyc();
         if (step && first == 0) first = i;
      end
      chk("mid_rst_first_step", 32'(first), 32'd10);

      // Random traffic against the scoreboard
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
         inc_req   = ($urandom_range(0, 19) == 0);
         dec_req   = ($urandom_range(0, 19) == 0);
         fast_req  = ($urandom_range(0, 24) == 0);
         slow_req  = ($urandom_range(0, 24) == 0);
         load      = ($urandom_range(0, 39) == 0);
         run       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) wrap_mode = ~wrap_mode;
         case ($urandom_range(0, 4))
            0:       load_value = 16'($urandom());
            1:       load_value = 16'h9999;
            2:       load_value = 16'h0000;
            3:       load_value = to_bcd($urandom_range(9990, 9999));
            default: load_value = to_bcd($urandom_range(0, 9999));
         endcase
         cyc();
      end

      @(negedge clk);
      #1 mon_en = 1'b0;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
